// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of an external fixed-latency ALU; issues one command at a time and
// holds each result until taken. Define ALU_CMDQ_ERRCHK_EN to flag sub underflow / divide-by-zero.
module alu_cmd_queue #(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_op,
   input  logic [15:0]            in_a,
   input  logic [15:0]            in_b,
   output logic [3:0]             alu_op,
   output logic [15:0]            alu_a,
   output logic [15:0]            alu_b,
   input  logic [31:0]            alu_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_data,
   output logic                   out_err,
   output logic [3:0]             out_op,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int LW = $clog2(ALU_LAT + 1);
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_NOP   = 4'd13;
   localparam logic [3:0] OP_ERR   = 4'd14;
   localparam logic [3:0] OP_FLUSH = 4'd15;
`ifdef ALU_CMDQ_ERRCHK_EN
   localparam bit ERRCHK = 1'b1;
`else
   localparam bit ERRCHK = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
   } cmd_t;

   state_t        state, next_state;
   cmd_t          mem [DEPTH];
   cmd_t          head, issue_q;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] lat_cnt;
   logic          ready_en, empty, head_flush;
   logic          push, pop, flush, capture, retire;
   logic [31:0]   res_data;
   logic          res_err;

   assign head       = mem[rd_ptr];
   assign empty      = (count == '0);
   assign head_flush = (head.op == OP_FLUSH);
   // A flush being popped this cycle clears the FIFO, so nothing may be pushed alongside it.
   assign in_ready   = ready_en && (count < CW'(DEPTH)) && !flush;
   assign push       = in_valid && in_ready;

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      flush      = 1'b0;
      capture    = 1'b0;
      retire     = 1'b0;
      case (state)
         IDLE: if (!empty) begin
            pop        = 1'b1;
            flush      = head_flush;
            next_state = head_flush ? IDLE : ISSUE;
         end
         ISSUE: next_state = WAIT;
         WAIT: if (issue_q.op == OP_NOP || lat_cnt <= LW'(1)) begin
            capture    = 1'b1;
            next_state = HOLD;
         end
         HOLD: if (out_ready) begin
            retire = 1'b1;
            if (!empty) begin
               pop        = 1'b1;
               flush      = head_flush;
               next_state = head_flush ? IDLE : ISSUE;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      res_data = alu_result;
      res_err  = 1'b0;
      if (issue_q.op == OP_NOP) begin
         res_data = '0;
      end else if (issue_q.op == OP_ERR) begin
         res_data = '0;
         res_err  = 1'b1;
      end else if (ERRCHK && ((issue_q.op == OP_SUB && issue_q.b > issue_q.a) ||
                              (issue_q.op == OP_DIV && issue_q.b == '0))) begin
         res_data = '0;
         res_err  = 1'b1;
      end
   end

   // NOTE: the storage array has no reset; only pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_op, in_a, in_b};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issue_q   <= '0;
         lat_cnt   <= '0;
         alu_op    <= OP_NOP;
         alu_a     <= '0;
         alu_b     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
         out_op    <= '0;
      end else begin
         if (pop && !flush) issue_q <= head;
         if (state == ISSUE) begin
            alu_op  <= issue_q.op;
            alu_a   <= issue_q.a;
            alu_b   <= issue_q.b;
            lat_cnt <= LW'(ALU_LAT);
         end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         if (capture) begin
            out_valid <= 1'b1;
            out_data  <= res_data;
            out_err   <= res_err;
            out_op    <= issue_q.op;
         end else if (retire) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: vector table, directed corner sequences and a
// randomized scoreboard run against an ALU model with two cycles of latency.
module tb_alu_cmd_queue;
   localparam int DEPTH   = 4;
   localparam int ALU_LAT = 2;
   localparam int CW      = $clog2(DEPTH) + 1;
   localparam int NV      = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready;
   logic [3:0]    in_op;
   logic [15:0]   in_a, in_b;
   logic [3:0]    alu_op;
   logic [15:0]   alu_a, alu_b;
   logic [31:0]   alu_result;
   logic          out_valid, out_ready;
   logic [31:0]   out_data;
   logic          out_err;
   logic [3:0]    out_op;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   alu_cmd_queue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err(out_err), .out_op(out_op), .count(count)
   );

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] xa, xb;
      xa = {16'h0, a};
      xb = {16'h0, b};
      case (op)
         4'd0:    return xa + xb;
         4'd1:    return xa - xb;
         4'd2:    return xa * xb;
         4'd3:    return (b == 16'h0) ? 32'hFFFF_FFFF : xa / xb;
         4'd4:    return xa & xb;
         4'd5:    return xa | xb;
         4'd6:    return xa ^ xb;
         4'd7:    return {16'h0, ~b};
         4'd8:    return xa << b[3:0];
         4'd9:    return xa >> b[3:0];
         4'd10:   return {31'h0, a < b};
         4'd11:   return {31'h0, a == b};
         4'd12:   return xa;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // External ALU: one register stage, so a result is valid two cycles after its operands change.
   logic [31:0] alu_pipe;
   always @(posedge clk) alu_pipe <= alu_f(alu_op, alu_a, alu_b);
   assign alu_result = alu_pipe;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] d;
      logic        e;
      logic [3:0]  op;
   } res_t;

   function automatic res_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      res_t r;
      r.op = op;
      r.e  = 1'b0;
      r.d  = alu_f(op, a, b);
      if (op == 4'd13) begin
         r.d = 32'h0;
      end else if (op == 4'd14) begin
         r.d = 32'h0;
         r.e = 1'b1;
      end
`ifdef ALU_CMDQ_ERRCHK_EN
      else if ((op == 4'd1 && b > a) || (op == 4'd3 && b == 16'h0)) begin
         r.d = 32'h0;
         r.e = 1'b1;
      end
`endif
      return r;
   endfunction

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] d;
      logic        e;
      int          lat;
   } vec_t;

   vec_t vt [NV];
   res_t sb [$];

   task automatic run_single(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             output logic [31:0] d, output logic e, output logic [3:0] o, output int lat);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      d = out_data; e = out_err; o = out_op;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        e;
      logic [3:0]  o;
      int          lat, acc, idx, nres, seen;
      logic        prev_stall;
      res_t        prev_res, exp_r;

      reset = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_a = 16'h0; in_b = 16'h0; out_ready = 1'b0;

      vt[0] = '{4'd0,  16'd5,      16'd4,      32'd9,          1'b0, ALU_LAT + 2};
      vt[1] = '{4'd2,  16'd5,      16'd4,      32'd20,         1'b0, ALU_LAT + 2};
      vt[2] = '{4'd4,  16'd5,      16'd4,      32'd4,          1'b0, ALU_LAT + 2};
      vt[3] = '{4'd7,  16'd5,      16'd4,      32'h0000_FFFB,  1'b0, ALU_LAT + 2};
      vt[4] = '{4'd13, 16'd7,      16'd7,      32'h0,          1'b0, 3};
      vt[5] = '{4'd14, 16'd1,      16'd2,      32'h0,          1'b1, ALU_LAT + 2};
`ifdef ALU_CMDQ_ERRCHK_EN
      vt[6] = '{4'd3,  16'd5,      16'd0,      32'h0,          1'b1, ALU_LAT + 2};
      vt[7] = '{4'd1,  16'd3,      16'd5,      32'h0,          1'b1, ALU_LAT + 2};
`else
      vt[6] = '{4'd3,  16'd5,      16'd0,      32'hFFFF_FFFF,  1'b0, ALU_LAT + 2};
      vt[7] = '{4'd1,  16'd3,      16'd5,      32'hFFFF_FFFE,  1'b0, ALU_LAT + 2};
`endif
      vt[8] = '{4'd0,  16'hFFFF,   16'hFFFF,   32'h0001_FFFE,  1'b0, ALU_LAT + 2};
      vt[9] = '{4'd2,  16'hFFFF,   16'hFFFF,   32'hFFFE_0001,  1'b0, ALU_LAT + 2};

      // Values while reset is held
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_alu_op", alu_op, 13);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_err", out_err, 0);
      check("rst_out_op", out_op, 0);
      reset = 1'b1;
      #1 check("ready_before_first_edge", in_ready, 0);
      @(posedge clk);
      #1 check("ready_after_first_edge", in_ready, 1);

      // Vector table, one command at a time from an empty queue
      for (int i = 0; i < NV; i++) begin
         run_single(vt[i].op, vt[i].a, vt[i].b, d, e, o, lat);
         check($sformatf("v%0d_data", i), d, vt[i].d);
         check($sformatf("v%0d_err", i), e, vt[i].e);
         check($sformatf("v%0d_op", i), o, vt[i].op);
         check($sformatf("v%0d_latency", i), lat, vt[i].lat);
         check($sformatf("v%0d_alu_op_held", i), alu_op, vt[i].op);
         check($sformatf("v%0d_alu_a_held", i), alu_a, vt[i].a);
         check($sformatf("v%0d_alu_b_held", i), alu_b, vt[i].b);
      end

      // Full queue: one result held, then five pushes against DEPTH=4
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd0; in_a = 16'd1; in_b = 16'd1;
      @(negedge clk);
      in_valid = 1'b0;
      idx = 0;
      while (!out_valid && idx < 40) begin
         @(negedge clk);
         idx++;
      end
      check("full_first_valid", out_valid, 1);
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = 4'd0; in_a = 16'(10 + i); in_b = 16'(i);
         #1;
         if (in_ready) acc++;
         if (i == 4) check("full_ready_low_5th", in_ready, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("full_accepted", acc, 4);
      check("full_count", count, 4);
      repeat (3) @(negedge clk);
      check("full_count_stalled", count, 4);
      check("full_hold_valid", out_valid, 1);
      check("full_hold_data", out_data, 2);
      out_ready = 1'b1;
      @(negedge clk);
      check("full_count_after_pop", count, 3);
      check("full_valid_released", out_valid, 0);
      idx = 0;
      for (int cyc = 0; cyc < 100 && idx < 4; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            check($sformatf("full_order_%0d", idx), out_data, 32'(10 + 2 * idx));
            idx++;
         end
      end
      check("full_results", idx, 4);
      repeat (2) @(negedge clk);
      check("full_drained_count", count, 0);

      // Flush: ops 0, 15, 0, 0 -> only the first produces a result
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_op = (i == 1) ? 4'd15 : 4'd0;
         in_a  = (i == 0) ? 16'd2 : 16'd7;
         in_b  = (i == 0) ? 16'd3 : 16'd7;
         #1;
         if (in_ready) acc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("flush_accepted", acc, 4);
      nres = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (out_valid) begin
            nres++;
            if (nres == 1) begin
               check("flush_first_data", out_data, 5);
               check("flush_ready_low", in_ready, 0);
            end
         end
         @(negedge clk);
      end
      check("flush_result_count", nres, 1);
      check("flush_count", count, 0);

      // Reset while a command is in WAIT with another still queued
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd0; in_a = 16'd1; in_b = 16'd2;
      @(negedge clk);
      in_a = 16'd3; in_b = 16'd4;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("prereset_count", count, 1);
      reset = 1'b0;
      #1;
      check("midrst_count", count, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_alu_op", alu_op, 13);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("postrst_no_valid", seen, 0);
      run_single(4'd0, 16'd5, 16'd4, d, e, o, lat);
      check("postrst_data", d, 9);
      check("postrst_err", e, 0);
      check("postrst_latency", lat, ALU_LAT + 2);

      // Randomized traffic against a result scoreboard
      prev_stall = 1'b0;
      prev_res   = '{32'h0, 1'b0, 4'h0};
      for (int cyc = 0; cyc < 420; cyc++) begin
         @(negedge clk);
         if (prev_stall) begin
            check("rand_hold_valid", out_valid, 1);
            check("rand_hold_data", out_data, prev_res.d);
            check("rand_hold_err", out_err, prev_res.e);
            check("rand_hold_op", out_op, prev_res.op);
         end
         in_valid  = (cyc < 300) && ($urandom_range(0, 9) < 7);
         in_op     = 4'($urandom_range(0, 14));
         in_a      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
         in_b      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
         out_ready = (cyc >= 300) || ($urandom_range(0, 9) < 6);
         #1;
         check("rand_count_le_depth", 32'(count <= CW'(DEPTH)), 1);
         if (in_valid && in_ready) sb.push_back(model(in_op, in_a, in_b));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rand_unexpected_result: got 0x%08h with no command outstanding", out_data);
            end else begin
               exp_r = sb.pop_front();
               check("rand_data", out_data, exp_r.d);
               check("rand_err", out_err, exp_r.e);
               check("rand_op", out_op, exp_r.op);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_res   = '{out_data, out_err, out_op};
      end
      check("rand_scoreboard_empty", sb.size(), 0);
      check("rand_final_count", count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 Parameter ALU_LAT, default 1, clock cycles from alu_op/alu_a/alu_b change to alu_result being valid (1..4).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  command present; in_ready  output  1  queue can accept.
REQ-006 in_op  input  4  opcode; 0..12 = ALU operations, 13 = no-op, 14 = error, 15 = flush.
REQ-007 in_a, in_b  input  16 each  operands.
REQ-008 alu_op  output  4; alu_a, alu_b  output  16 each  operation and operands driven to the ALU.
REQ-009 alu_result  input  32  ALU output.
REQ-010 out_valid  output  1; out_ready  input  1; out_data  output  32; out_err  output  1; out_op  output  4  result channel.
REQ-011 count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-012 Command accepted on the cycle in_valid && in_ready; in_ready = (count < DEPTH) and not in flush.
REQ-013 FIFO order strictly first-in first-out; pointers wrap modulo DEPTH.
REQ-014 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-015 IDLE: FIFO non-empty -> pop head into issue register, go to ISSUE; empty -> stay.
REQ-016 ISSUE: drive alu_op/alu_a/alu_b from issue register, load latency counter with ALU_LAT, go to WAIT.
REQ-017 WAIT: decrement counter; at zero capture alu_result into out_data, set out_valid, go to HOLD.
REQ-018 HOLD: out_data/out_err/out_op stable while out_valid && !out_ready; on out_ready go to IDLE, or directly to ISSUE with next head if FIFO non-empty (one bubble-free pop).
REQ-019 Issue latency, empty queue: out_valid asserts ALU_LAT+2 cycles after the accepting edge.
REQ-020 alu_op/alu_a/alu_b hold their last issued value in all states except ISSUE.
REQ-021 Op 13: bypasses ALU wait; result 32'h0, out_err 0, one cycle in WAIT regardless of ALU_LAT.
REQ-022 Op 14: result 32'h0, out_err 1.
REQ-023 Op 15 (flush): when popped, discards all remaining FIFO entries, produces no result, returns to IDLE; in_ready low during that cycle.
REQ-024 Simultaneous push and pop on a full FIFO: push refused (in_ready already low); on non-full FIFO both take effect, count unchanged.
REQ-025 out_data is zero-extended 32-bit ALU result; no truncation.

Reset
REQ-026 reset low asynchronously: FSM to IDLE, FIFO pointers and count 0, out_valid 0, out_data 0, out_err 0, out_op 0, alu_op 4'd13, alu_a 0, alu_b 0, in_ready 0 while asserted.
REQ-027 Reset mid-operation discards in-flight command and held result; no out_valid until a new command is accepted.
REQ-028 in_ready rises on the first clock edge after reset deasserts.

Configuration
REQ-029 Macro ALU_CMDQ_ERRCHK_EN defined: out_err also set for op 1 with in_b > in_a (underflow) and op 3 with in_b == 0 (divide by zero); out_data forced 32'h0 in those cases.
REQ-030 Macro undefined: out_err set only for op 14; out_data is alu_result unmodified for ops 0..12.

Verification
REQ-031 Push op 0, a=5, b=4, out_ready=1 -> out_valid after ALU_LAT+2 cycles, out_data=9, out_err=0.
REQ-032 Push 5 commands back-to-back with out_ready=0, DEPTH=4 -> 4 accepted, in_ready low on 5th, count=4 until first pop frees a slot after HOLD releases.
REQ-033 Push op 2 (5x4), op 4 (5&4), op 7 (~4) -> results 20, 4, 32'h0000FFFB in order.
REQ-034 Push op 3 a=5 b=0 -> with ALU_CMDQ_ERRCHK_EN out_err=1, out_data=0; without, out_err=0.
REQ-035 Queue ops 0, 15, 0, 0 -> one result (op 0), remaining entries discarded, count=0.
REQ-036 Assert reset during WAIT -> out_valid 0, count 0 immediately; next command behaves as REQ-031.
